// File: rtl/pattern_match_multi.sv
// NUM_PAT-entry masked word matcher: 2-stage pipeline, priority index, saturating hit counters.
// Define PATTERN_MATCH_STICKY_EN to add sticky per-entry hit flags (sticky_clr / sticky_vec).
module pattern_match_multi #(
  parameter int DATA_W  = 80,
  parameter int NUM_PAT = 4,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [DATA_W-1:0]  cfg_mask,
  input  logic [DATA_W-1:0]  cfg_value,
  input  logic               cfg_en,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  pattern_in,
  input  logic               cnt_clr,
  input  logic [IDX_W-1:0]   cnt_sel,
`ifdef PATTERN_MATCH_STICKY_EN
  input  logic               sticky_clr,
`endif
  output logic               match_valid,
  output logic [NUM_PAT-1:0] match_vec,
  output logic               match_any,
  output logic [IDX_W-1:0]   match_idx,
  output logic [CNT_W-1:0]   cnt_out
`ifdef PATTERN_MATCH_STICKY_EN
  ,
  output logic [NUM_PAT-1:0] sticky_vec
`endif
);

  localparam int NUM_CHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W     = NUM_CHUNK * CHUNK_W;

  logic [DATA_W-1:0] r_mask  [NUM_PAT];
  logic [DATA_W-1:0] r_value [NUM_PAT];
  logic [NUM_PAT-1:0] r_en;

  // NOTE: the pattern table is a register array, not a RAM, so it can and must be
  // cleared by reset: a disabled-all table is the only safe power-up state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_PAT; k++) begin
        r_mask[k]  <= '0;
        r_value[k] <= '0;
      end
      r_en <= '0;
    end else if (cfg_we) begin
      for (int k = 0; k < NUM_PAT; k++) begin
        if (cfg_idx == IDX_W'(k)) begin
          r_mask[k]  <= cfg_mask;
          r_value[k] <= cfg_value & cfg_mask;
          r_en[k]    <= cfg_en;
        end
      end
    end
  end

  // Stage 1 compare: XOR difference zero-padded to whole chunks, one equality bit per chunk.
  logic [NUM_CHUNK-1:0] w_chunk_eq [NUM_PAT];

  // NOTE: every always_comb output gets a default before any conditional or loop,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    logic [PAD_W-1:0] w_diff;
    w_diff = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      w_chunk_eq[k] = '0;
    end
    for (int k = 0; k < NUM_PAT; k++) begin
      w_diff = PAD_W'((pattern_in & r_mask[k]) ^ r_value[k]);
      for (int c = 0; c < NUM_CHUNK; c++) begin
        w_chunk_eq[k][c] = (w_diff[c*CHUNK_W +: CHUNK_W] == '0);
      end
    end
  end

  logic                 r_s1_valid;
  logic [NUM_CHUNK-1:0] r_s1_eq [NUM_PAT];
  logic [NUM_PAT-1:0]   r_s1_en;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_en    <= '0;
      for (int k = 0; k < NUM_PAT; k++) begin
        r_s1_eq[k] <= '0;
      end
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_eq <= w_chunk_eq;
        r_s1_en <= r_en;
      end
    end
  end

  logic [NUM_PAT-1:0] w_match;
  logic [IDX_W-1:0]   w_idx;

  always_comb begin
    w_match = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      w_match[k] = r_s1_valid & r_s1_en[k] & (&r_s1_eq[k]);
    end
    for (int k = NUM_PAT - 1; k >= 0; k--) begin
      if (w_match[k]) w_idx = IDX_W'(k);
    end
  end

  logic               r_match_valid;
  logic [NUM_PAT-1:0] r_match_vec;
  logic               r_match_any;
  logic [IDX_W-1:0]   r_match_idx;
  logic [CNT_W-1:0]   r_cnt [NUM_PAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match_valid <= 1'b0;
      r_match_vec   <= '0;
      r_match_any   <= 1'b0;
      r_match_idx   <= '0;
    end else begin
      r_match_valid <= r_s1_valid;
      r_match_vec   <= w_match;
      r_match_any   <= |w_match;
      r_match_idx   <= w_idx;
    end
  end

  // Counters advance on the same edge that registers the hit; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_PAT; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PAT; k++) begin
        if (cnt_clr) begin
          r_cnt[k] <= '0;
        end else if (w_match[k] && (r_cnt[k] != '1)) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      if (cnt_sel == IDX_W'(k)) cnt_out = r_cnt[k];
    end
  end

  assign match_valid = r_match_valid;
  assign match_vec   = r_match_vec;
  assign match_any   = r_match_any;
  assign match_idx   = r_match_idx;

`ifdef PATTERN_MATCH_STICKY_EN
  logic [NUM_PAT-1:0] r_sticky;

  // A new hit in the clearing cycle keeps its bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= w_match | (r_sticky & ~{NUM_PAT{sticky_clr}});
    end
  end

  assign sticky_vec = r_sticky;
`else
  // Sticky flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_pattern_match_multi.sv
// Self-checking bench for pattern_match_multi: directed table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_pattern_match_multi;

  localparam int DW   = 80;
  localparam int NP   = 4;
  localparam int CW   = 12;
  localparam int CNTW = 4;
  localparam int IW   = 2;
  localparam logic [CNTW-1:0] CMAX = '1;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_we;
  logic [IW-1:0]  cfg_idx;
  logic [DW-1:0]  cfg_mask;
  logic [DW-1:0]  cfg_value;
  logic           cfg_en;
  logic           in_valid;
  logic [DW-1:0]  pattern_in;
  logic           cnt_clr;
  logic [IW-1:0]  cnt_sel;
  logic           sticky_clr;
  logic           match_valid;
  logic [NP-1:0]  match_vec;
  logic           match_any;
  logic [IW-1:0]  match_idx;
  logic [CNTW-1:0] cnt_out;
  logic [NP-1:0]  sticky_vec;

  pattern_match_multi #(
    .DATA_W (DW),
    .NUM_PAT(NP),
    .CHUNK_W(CW),
    .CNT_W  (CNTW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_mask   (cfg_mask),
    .cfg_value  (cfg_value),
    .cfg_en     (cfg_en),
    .in_valid   (in_valid),
    .pattern_in (pattern_in),
    .cnt_clr    (cnt_clr),
    .cnt_sel    (cnt_sel),
`ifdef PATTERN_MATCH_STICKY_EN
    .sticky_clr (sticky_clr),
`endif
    .match_valid(match_valid),
    .match_vec  (match_vec),
    .match_any  (match_any),
    .match_idx  (match_idx),
    .cnt_out    (cnt_out)
`ifdef PATTERN_MATCH_STICKY_EN
    ,
    .sticky_vec (sticky_vec)
`endif
  );

`ifndef PATTERN_MATCH_STICKY_EN
  assign sticky_vec = '0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pattern table, counters, and the word results in flight.
  logic [DW-1:0]   m_mask  [NP];
  logic [DW-1:0]   m_value [NP];
  logic [NP-1:0]   m_en;
  logic [CNTW-1:0] m_cnt   [NP];
  logic [NP-1:0]   m_sticky;
  logic            p_valid;
  logic [NP-1:0]   p_vec;
  logic            e_valid;
  logic [NP-1:0]   e_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_w();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic logic [IW-1:0] lowest(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) begin
      if (v[i]) return IW'(i);
    end
    return '0;
  endfunction

  function automatic logic [NP-1:0] model_match(input logic [DW-1:0] w);
    logic [NP-1:0] r;
    r = '0;
    for (int k = 0; k < NP; k++) begin
      r[k] = m_en[k] && ((w & m_mask[k]) == m_value[k]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      m_mask[k] = '0; m_value[k] = '0; m_cnt[k] = '0;
    end
    m_en = '0; m_sticky = '0;
    p_valid = 1'b0; p_vec = '0; e_valid = 1'b0; e_vec = '0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs, then pass the edge.
  task automatic tick();
    e_valid = p_valid;
    e_vec   = p_vec;
    for (int k = 0; k < NP; k++) begin
      if (cnt_clr) m_cnt[k] = '0;
      else if (p_vec[k] && m_cnt[k] != CMAX) m_cnt[k] = m_cnt[k] + 1'b1;
    end
    m_sticky = p_vec | (sticky_clr ? '0 : m_sticky);
    p_valid = in_valid;
    p_vec   = in_valid ? model_match(pattern_in) : '0;
    if (cfg_we && int'(cfg_idx) < NP) begin
      m_mask[cfg_idx]  = cfg_mask;
      m_value[cfg_idx] = cfg_value & cfg_mask;
      m_en[cfg_idx]    = cfg_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [CNTW-1:0] ec;
    ec = (int'(cnt_sel) < NP) ? m_cnt[cnt_sel] : '0;
    check({tag, "_valid"}, 32'(match_valid), 32'(e_valid));
    check({tag, "_vec"},   32'(match_vec),   32'(e_vec));
    check({tag, "_any"},   32'(match_any),   32'(|e_vec));
    check({tag, "_idx"},   32'(match_idx),   32'(lowest(e_vec)));
    check({tag, "_cnt"},   32'(cnt_out),     32'(ec));
`ifdef PATTERN_MATCH_STICKY_EN
    check({tag, "_sticky"}, 32'(sticky_vec), 32'(m_sticky));
`endif
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [DW-1:0] mask,
                           input logic [DW-1:0] value, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_mask = mask; cfg_value = value; cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [IW-1:0] idx;
    logic [DW-1:0] mask;
    logic [DW-1:0] value;
    logic          en;
    logic          vld;
    logic [DW-1:0] pat;
    logic          e_vld;
    logic [NP-1:0] e_vec;
    logic [IW-1:0] e_idx;
    logic [CNTW-1:0] e_cnt;
  } row_t;

  localparam int NROW = 16;
  row_t tbl [NROW];

  initial begin
    // Expected fields describe the result of that row's word; e_cnt is counter 2 at that time.
    tbl[0]  = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'h0,      1'b1, 4'b0000, 2'd0, 4'd0};
    tbl[1]  = '{1'b1, 2'd2, 80'hFF, 80'h5A,     1'b1, 1'b0, 80'h0,      1'b0, 4'b0000, 2'd0, 4'd0};
    tbl[2]  = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'h12345A, 1'b1, 4'b0100, 2'd2, 4'd1};
    tbl[3]  = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'h12345B, 1'b1, 4'b0000, 2'd0, 4'd1};
    tbl[4]  = '{1'b1, 2'd1, 80'h0,  80'h0,      1'b1, 1'b0, 80'h0,      1'b0, 4'b0000, 2'd0, 4'd1};
    tbl[5]  = '{1'b1, 2'd3, 80'h0,  80'h0,      1'b1, 1'b1, 80'h12345B, 1'b1, 4'b0010, 2'd1, 4'd1};
    tbl[6]  = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'h777,    1'b1, 4'b1010, 2'd1, 4'd1};
    tbl[7]  = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b0, 80'h777,    1'b0, 4'b0000, 2'd0, 4'd1};
    tbl[8]  = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'h5A,     1'b1, 4'b1110, 2'd1, 4'd2};
    tbl[9]  = '{1'b1, 2'd0, {DW{1'b1}}, 80'hABCD, 1'b1, 1'b1, 80'hABCD, 1'b1, 4'b1010, 2'd1, 4'd2};
    tbl[10] = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'hABCD,   1'b1, 4'b1011, 2'd0, 4'd2};
    tbl[11] = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'h5A,     1'b1, 4'b1110, 2'd1, 4'd3};
    tbl[12] = '{1'b1, 2'd1, 80'h0,  80'h0,      1'b0, 1'b1, 80'h0,      1'b1, 4'b1010, 2'd1, 4'd3};
    tbl[13] = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'h0,      1'b1, 4'b1000, 2'd3, 4'd3};
    tbl[14] = '{1'b1, 2'd2, 80'hFF, 80'hFFFF5A, 1'b1, 1'b0, 80'h0,      1'b0, 4'b0000, 2'd0, 4'd3};
    tbl[15] = '{1'b0, 2'd0, 80'h0,  80'h0,      1'b0, 1'b1, 80'h5A,     1'b1, 4'b1100, 2'd2, 4'd4};

    reset = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_mask = '0; cfg_value = '0; cfg_en = 1'b0;
    in_valid = 1'b0; pattern_in = '0; cnt_clr = 1'b0; cnt_sel = '0; sticky_clr = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(match_valid), 32'd0);
    check("rst_vec",   32'(match_vec),   32'd0);
    check("rst_any",   32'(match_any),   32'd0);
    check("rst_idx",   32'(match_idx),   32'd0);
    check("rst_cnt",   32'(cnt_out),     32'd0);
    check("rst_sticky", 32'(sticky_vec), 32'd0);
    reset = 1'b0;

    // Directed table; row i's result appears after the edge that samples row i+1.
    cnt_sel = 2'd2;
    for (int i = 0; i <= NROW; i++) begin
      if (i < NROW) begin
        cfg_we = tbl[i].we; cfg_idx = tbl[i].idx; cfg_mask = tbl[i].mask;
        cfg_value = tbl[i].value; cfg_en = tbl[i].en;
        in_valid = tbl[i].vld; pattern_in = tbl[i].pat;
      end else begin
        cfg_we = 1'b0; in_valid = 1'b0;
      end
      tick();
      if (i > 0) begin
        check($sformatf("row%0d_valid", i-1), 32'(match_valid), 32'(tbl[i-1].e_vld));
        check($sformatf("row%0d_vec", i-1),   32'(match_vec),   32'(tbl[i-1].e_vec));
        check($sformatf("row%0d_any", i-1),   32'(match_any),   32'(|tbl[i-1].e_vec));
        check($sformatf("row%0d_idx", i-1),   32'(match_idx),   32'(tbl[i-1].e_idx));
        check($sformatf("row%0d_cnt", i-1),   32'(cnt_out),     32'(tbl[i-1].e_cnt));
      end
    end
    cfg_we = 1'b0;

    // Counter saturation at 4'hF, then clear colliding with a hit.
    cnt_sel = 2'd0;
    cfg_write(2'd0, '0, '0, 1'b1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pattern_in = rand_w();
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("sat_cnt", 32'(cnt_out), 32'hF);
    check_model("sat");
    in_valid = 1'b1;
    repeat (2) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_hit_vec0", 32'(match_vec[0]), 32'd1);
    check("clr_wins_cnt", 32'(cnt_out), 32'd0);
    tick();
    check("after_clr_cnt", 32'(cnt_out), 32'd1);
    check_model("clr");
    in_valid = 1'b0;
    repeat (2) tick();

`ifdef PATTERN_MATCH_STICKY_EN
    // Single hit on entry 1 sets and holds its sticky bit until sticky_clr.
    cfg_write(2'd0, '0, '0, 1'b0);
    cfg_write(2'd2, '0, '0, 1'b0);
    cfg_write(2'd3, '0, '0, 1'b0);
    cfg_write(2'd1, 80'hFF, 80'h11, 1'b1);
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("sticky_cleared", 32'(sticky_vec), 32'd0);
    in_valid = 1'b1; pattern_in = 80'h11;
    tick();
    pattern_in = 80'h22;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("sticky_hold%0d", i), 32'(sticky_vec), 32'b0010);
    end
    in_valid = 1'b0;
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("sticky_clr", 32'(sticky_vec), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int j;
      int kind;
      cfg_we  = ($urandom_range(0, 9) == 0);
      cfg_idx = IW'($urandom_range(0, NP-1));
      kind = $urandom_range(0, 2);
      cfg_mask = (kind == 0) ? '0 : (kind == 1) ? rand_w() : (rand_w() & rand_w() & rand_w());
      cfg_value = rand_w();
      cfg_en = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 4) != 0);
      j = $urandom_range(0, NP-1);
      pattern_in = ($urandom_range(0, 1) == 1) ? (m_value[j] | (rand_w() & ~m_mask[j])) : rand_w();
      cnt_clr = ($urandom_range(0, 30) == 0);
      cnt_sel = IW'($urandom_range(0, NP-1));
      sticky_clr = ($urandom_range(0, 15) == 0);
      tick();
      check_model($sformatf("rnd%0d", n));
    end
    cfg_we = 1'b0; cnt_clr = 1'b0; sticky_clr = 1'b0;

    // Asynchronous reset with words in flight.
    cfg_write(2'd0, '0, '0, 1'b1);
    in_valid = 1'b1;
    repeat (3) tick();
    check("pre_rst_valid", 32'(match_valid), 32'd1);
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("arst_valid", 32'(match_valid), 32'd0);
    check("arst_vec",   32'(match_vec),   32'd0);
    check("arst_any",   32'(match_any),   32'd0);
    check("arst_idx",   32'(match_idx),   32'd0);
    check("arst_cnt",   32'(cnt_out),     32'd0);
    check("arst_sticky", 32'(sticky_vec), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid%0d", i), 32'(match_valid), 32'd0);
    end
    in_valid = 1'b1; pattern_in = rand_w();
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_cfg_valid", 32'(match_valid), 32'd1);
    check("post_rst_cfg_vec",   32'(match_vec),   32'd0);
    check_model("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
